// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: edge-detected start/stop, lap and clear buttons drive a
// four-state FSM; a six-digit BCD counter (mm:ss.cc) advances on a 100 Hz tick.
// The display shows the frozen lap value while in LAP, otherwise the live count.
module stopwatch_ctrl #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic [23:0] disp,
  output logic [1:0]  state,
  output logic        running,
  output logic        lap_active
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;

  localparam logic [23:0] MAX_TIME = 24'h595999;

  logic [1:0]  state_q, state_d;
  logic [23:0] live_q, live_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] disp_q, disp_d;
  logic        ss_prev_q, lap_prev_q, clr_prev_q;
  logic        ev_ss, ev_lap, ev_clr;
  logic        counting;

  // Add one centisecond to a packed BCD time, rippling carries through all
  // six digits in one step. Any out-of-range digit is treated as at-limit so
  // it can never be propagated onto the display.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] >= lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Rising-edge events: a held level only fires once, release never fires.
  assign ev_ss  = btn_ss  & ~ss_prev_q;
  assign ev_lap = btn_lap & ~lap_prev_q;
  assign ev_clr = btn_clr & ~clr_prev_q;

  // Counting is decided by the pre-edge state so a same-edge transition
  // cannot add or drop a tick.
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);

  // Next-state, counter, lap capture and display selection.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    lap_d   = lap_q;

    // Events are checked in priority order clr > ss > lap; only the first one
    // legal in the current state acts, the rest are dropped.
    case (state_q)
      S_IDLE: begin
        if (ev_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ev_ss) begin
          state_d = S_PAUSE;
        end else if (ev_lap) begin
          state_d = S_LAP;
          lap_d   = live_q;
        end
      end
      S_LAP: begin
        if (ev_ss) state_d = S_PAUSE;
        else if (ev_lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clr) begin
          state_d = S_IDLE;
          live_d  = '0;
        end else if (ev_ss) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Saturation at the top of the range overrides any button transition.
    if (counting && tick) begin
      if ((live_q == MAX_TIME) && (WRAP_EN == 1'b0)) begin
        state_d = S_PAUSE;
      end else begin
        live_d = bcd_inc(live_q);
      end
    end

    disp_d = (state_d == S_LAP) ? lap_d : live_d;
  end

  // State, counter, lap register, display and button history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      // Start high so a button held through reset must be released first.
      ss_prev_q  <= 1'b1;
      lap_prev_q <= 1'b1;
      clr_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      ss_prev_q  <= btn_ss;
      lap_prev_q <= btn_lap;
      clr_prev_q <= btn_clr;
    end
  end

  assign disp       = disp_q;
  assign state      = state_q;
  assign running    = state_q[0];
  assign lap_active = (state_q == S_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a table of per-cycle vectors, hand-written corner
// sequences, and a randomized run against a centisecond-based reference model.
module tb_stopwatch_ctrl;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  logic        clk;
  logic        rst, tick, btn_ss, btn_lap, btn_clr;
  logic [23:0] disp, disp_s;
  logic [1:0]  state, state_s;
  logic        running, running_s, lap_active, lap_active_s;

  int n_vec = 0;
  int n_err = 0;

  stopwatch_ctrl #(.WRAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .disp(disp), .state(state), .running(running),
    .lap_active(lap_active)
  );

  stopwatch_ctrl #(.WRAP_EN(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .tick(tick), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .disp(disp_s), .state(state_s), .running(running_s),
    .lap_active(lap_active_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r, t, s, l, c;
    logic [23:0] d;
    logic [1:0]  st;
    logic        rn, la;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(logic r, logic t, logic s, logic l, logic c,
                              logic [23:0] d, logic [1:0] st, logic rn, logic la);
    vec_t v;
    v.r = r; v.t = t; v.s = s; v.l = l; v.c = c;
    v.d = d; v.st = st; v.rn = rn; v.la = la;
    return v;
  endfunction

  task automatic drive(input logic r, input logic t, input logic s,
                       input logic l, input logic c);
    @(negedge clk);
    rst = r; tick = t; btn_ss = s; btn_lap = l; btn_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b1, btn_ss, btn_lap, btn_clr);
  endtask

  task automatic check(input string name,
                       input logic [23:0] ad, input logic [1:0] ast, input logic arn, input logic ala,
                       input logic [23:0] ed, input logic [1:0] est, input logic ern, input logic ela);
    n_vec++;
    if (ad !== ed || ast !== est || arn !== ern || ala !== ela) begin
      n_err++;
      $display("FAIL %s: got disp=%06h state=%b running=%b lap_active=%b, want disp=%06h state=%b running=%b lap_active=%b",
               name, ad, ast, arn, ala, ed, est, ern, ela);
    end
  endtask

  task automatic chk(input string name, input logic [23:0] ed, input logic [1:0] est);
    check(name, disp, state, running, lap_active, ed, est,
          (est == RUN) || (est == LAP), est == LAP);
  endtask

  task automatic chk_sat(input string name, input logic [23:0] ed, input logic [1:0] est);
    check(name, disp_s, state_s, running_s, lap_active_s, ed, est,
          (est == RUN) || (est == LAP), est == LAP);
  endtask

  // Reference model: time held as an integer count of centiseconds.
  int   m_st, m_cs, m_lap;
  logic p_ss, p_lap, p_clr;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic model_step(input logic r, input logic t, input logic s,
                            input logic l, input logic c);
    logic es, el, ec, cnt;
    int   nst;
    if (r) begin
      m_st = IDLE; m_cs = 0; m_lap = 0;
      p_ss = 1'b1; p_lap = 1'b1; p_clr = 1'b1;
      return;
    end
    es  = s && !p_ss;
    el  = l && !p_lap;
    ec  = c && !p_clr;
    cnt = t && (m_st == RUN || m_st == LAP);
    nst = m_st;
    if (ec && m_st == PAUSE) begin
      nst  = IDLE;
      m_cs = 0;
    end else if (es) begin
      nst = (m_st == IDLE || m_st == PAUSE) ? RUN : PAUSE;
    end else if (el && m_st == RUN) begin
      nst   = LAP;
      m_lap = m_cs;
    end else if (el && m_st == LAP) begin
      nst = RUN;
    end
    if (cnt) m_cs = (m_cs == 359999) ? 0 : m_cs + 1;
    m_st  = nst;
    p_ss  = s; p_lap = l; p_clr = c;
  endtask

  initial begin
    logic r, t, s, l, c;
    rst = 1'b1; tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;

    // Per-cycle vectors: {rst, tick, ss, lap, clr} -> outputs after the edge.
    vecs[0]  = mk(1,0,0,0,0, 24'h000000, IDLE,  0,0);
    vecs[1]  = mk(0,0,0,0,0, 24'h000000, IDLE,  0,0);
    vecs[2]  = mk(0,1,0,0,0, 24'h000000, IDLE,  0,0);
    vecs[3]  = mk(0,0,1,0,0, 24'h000000, RUN,   1,0);
    vecs[4]  = mk(0,1,1,0,0, 24'h000001, RUN,   1,0);
    vecs[5]  = mk(0,1,0,0,0, 24'h000002, RUN,   1,0);
    vecs[6]  = mk(0,0,0,1,0, 24'h000002, LAP,   1,1);
    vecs[7]  = mk(0,1,0,1,0, 24'h000002, LAP,   1,1);
    vecs[8]  = mk(0,1,0,0,0, 24'h000002, LAP,   1,1);
    vecs[9]  = mk(0,0,0,1,0, 24'h000004, RUN,   1,0);
    vecs[10] = mk(0,1,0,1,0, 24'h000005, RUN,   1,0);
    vecs[11] = mk(0,1,0,0,1, 24'h000006, RUN,   1,0);
    vecs[12] = mk(0,1,1,0,0, 24'h000007, PAUSE, 0,0);
    vecs[13] = mk(0,1,0,0,0, 24'h000007, PAUSE, 0,0);
    vecs[14] = mk(0,0,0,1,0, 24'h000007, PAUSE, 0,0);
    vecs[15] = mk(0,0,0,0,1, 24'h000000, IDLE,  0,0);
    vecs[16] = mk(0,0,1,0,0, 24'h000000, RUN,   1,0);
    vecs[17] = mk(0,1,0,0,0, 24'h000001, RUN,   1,0);
    vecs[18] = mk(0,1,1,1,1, 24'h000002, PAUSE, 0,0);
    vecs[19] = mk(0,0,0,0,0, 24'h000002, PAUSE, 0,0);
    vecs[20] = mk(0,0,1,1,0, 24'h000002, RUN,   1,0);
    vecs[21] = mk(0,1,0,0,0, 24'h000003, RUN,   1,0);
    vecs[22] = mk(0,0,0,1,0, 24'h000003, LAP,   1,1);
    vecs[23] = mk(0,1,1,1,0, 24'h000004, PAUSE, 0,0);
    vecs[24] = mk(0,0,0,0,0, 24'h000004, PAUSE, 0,0);
    vecs[25] = mk(0,0,1,0,1, 24'h000000, IDLE,  0,0);
    vecs[26] = mk(1,0,0,0,0, 24'h000000, IDLE,  0,0);
    vecs[27] = mk(0,0,0,0,0, 24'h000000, IDLE,  0,0);
    vecs[28] = mk(0,0,1,0,0, 24'h000000, RUN,   1,0);
    vecs[29] = mk(0,1,0,0,0, 24'h000001, RUN,   1,0);
    vecs[30] = mk(0,0,1,1,0, 24'h000001, PAUSE, 0,0);
    vecs[31] = mk(0,0,0,1,0, 24'h000001, PAUSE, 0,0);
    vecs[32] = mk(0,0,1,1,0, 24'h000001, RUN,   1,0);
    vecs[33] = mk(0,0,0,1,0, 24'h000001, RUN,   1,0);

    for (int i = 0; i < 34; i++) begin
      drive(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].l, vecs[i].c);
      check($sformatf("vec%0d", i), disp, state, running, lap_active,
            vecs[i].d, vecs[i].st, vecs[i].rn, vecs[i].la);
    end

    // Asynchronous reset mid-count, checked before any clock edge.
    drive(0,1,0,0,0);
    drive(0,1,0,0,0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst", 24'h000000, IDLE);

    // 150 ticks then stop.
    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    tick_n(150);
    drive(0,0,1,0,0);
    chk("run150_stop", 24'h000150, PAUSE);

    // Lap freeze and release.
    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    tick_n(1234);
    chk("at_12_34", 24'h001234, RUN);
    drive(0,0,0,1,0);
    chk("lap_enter", 24'h001234, LAP);
    drive(0,0,0,0,0);
    tick_n(100);
    chk("lap_frozen", 24'h001234, LAP);
    drive(0,0,0,1,0);
    chk("lap_release", 24'h001334, RUN);

    // Clear beats start/stop in PAUSE; held ss afterwards does nothing.
    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    tick_n(5);
    drive(0,0,1,0,0);
    chk("pause5", 24'h000005, PAUSE);
    drive(0,0,0,0,0);
    drive(0,0,1,0,1);
    chk("clr_over_ss", 24'h000000, IDLE);
    drive(0,0,1,0,0);
    tick_n(10);
    chk("ss_held_idle", 24'h000000, IDLE);

    // Top-of-range behaviour, wrap versus saturate.
    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    dut.live_q     = 24'h595999;
    dut_sat.live_q = 24'h595999;
    drive(0,1,0,0,0);
    chk("wrap", 24'h000000, RUN);
    chk_sat("saturate", 24'h595999, PAUSE);
    drive(0,1,0,0,0);
    chk("wrap_next", 24'h000001, RUN);
    chk_sat("saturate_hold", 24'h595999, PAUSE);

    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    drive(0,0,0,1,0);
    drive(0,0,0,0,0);
    dut.live_q     = 24'h595999;
    dut_sat.live_q = 24'h595999;
    drive(0,1,0,0,0);
    chk("wrap_in_lap", 24'h000000, LAP);
    chk_sat("saturate_in_lap", 24'h595999, PAUSE);
    drive(0,0,0,1,0);
    chk("wrap_lap_release", 24'h000000, RUN);

    // Stop coincident with a tick still counts that tick.
    drive(1,0,0,0,0);
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    drive(0,0,0,0,0);
    tick_n(9);
    chk("at_0_09", 24'h000009, RUN);
    drive(0,1,1,0,0);
    chk("stop_with_tick", 24'h000010, PAUSE);
    tick_n(5);
    chk("pause_ignores_ticks", 24'h000010, PAUSE);

    // Buttons held through reset release fire nothing until re-pressed.
    drive(0,0,0,0,0);
    drive(0,0,1,0,0);
    tick_n(3);
    drive(1,0,0,1,0);
    chk("rst_lap_held", 24'h000000, IDLE);
    drive(0,1,0,1,0);
    chk("rst_release_lap_held", 24'h000000, IDLE);
    drive(0,0,1,1,0);
    chk("start_lap_held", 24'h000000, RUN);
    drive(0,1,0,1,0);
    chk("no_lap_while_held", 24'h000001, RUN);
    drive(0,0,0,0,0);
    drive(0,0,0,1,0);
    chk("lap_after_repress", 24'h000001, LAP);
    drive(1,0,1,0,0);
    drive(0,0,1,0,0);
    chk("rst_ss_held", 24'h000000, IDLE);

    // Randomized run against the reference model.
    r = 1'b1; t = 1'b0; s = 1'b0; l = 1'b0; c = 1'b0;
    model_step(r, t, s, l, c);
    drive(r, t, s, l, c);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 63) == 0);
      t = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) s = ~s;
      if ($urandom_range(0, 3) == 0) l = ~l;
      if ($urandom_range(0, 5) == 0) c = ~c;
      model_step(r, t, s, l, c);
      drive(r, t, s, l, c);
      check($sformatf("rand%0d", i), disp, state, running, lap_active,
            (m_st == LAP) ? to_bcd(m_lap) : to_bcd(m_cs), 2'(m_st),
            (m_st == RUN) || (m_st == LAP), m_st == LAP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter WRAP_EN, default 1: 1 = roll over 59:59.99 -> 00:00.00; 0 = saturate and pause.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  100 Hz count enable, one clk wide.
REQ-005 btn_ss  input  1  start/stop button, synchronized debounced level.
REQ-006 btn_lap  input  1  lap button, synchronized debounced level.
REQ-007 btn_clr  input  1  clear button, synchronized debounced level.
REQ-008 disp  output  24  six BCD digits {m10,m1,s10,s1,c10,c1}, registered.
REQ-009 state  output  2  FSM state code: IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-010 running  output  1  high in RUN and LAP.
REQ-011 lap_active  output  1  high in LAP only.

Function
REQ-012 Each button SHALL have an internal previous-sample register; an event SHALL fire in any cycle where btn=1 and prev=0, and the FSM SHALL act on it at that same clock edge.
REQ-013 A held button SHALL produce exactly one event; release SHALL produce none.
REQ-014 Simultaneous events SHALL be resolved by priority clr > ss > lap; only the highest-priority event legal in the current state SHALL act, the rest SHALL be discarded, not queued.
REQ-015 IDLE: ss -> RUN; lap, clr ignored.
REQ-016 RUN: ss -> PAUSE; lap -> LAP with lap register loaded; clr ignored.
REQ-017 LAP: lap -> RUN (display released to live); ss -> PAUSE (display live); clr ignored.
REQ-018 PAUSE: ss -> RUN; clr -> IDLE with live counter zeroed at the same edge; lap ignored.
REQ-019 Live counter SHALL increment by 0.01 s on tick only when the current (pre-edge) state is RUN or LAP; a transition at the same edge SHALL NOT affect that increment.
REQ-020 Digit ranges: c1, c10, s1, m1 0-9; s10, m10 0-5; carries SHALL ripple within the same cycle (e.g. 00:59.99 -> 01:00.00 on one tick).
REQ-021 At 59:59.99 with tick: WRAP_EN=1 -> 00:00.00, state unchanged; WRAP_EN=0 -> value held at 59:59.99 and state -> PAUSE (LAP also -> PAUSE).
REQ-022 Lap register SHALL capture the live counter value before any concurrent tick increment.
REQ-023 disp SHALL equal lap register when next state is LAP, otherwise the next live counter value; it SHALL update at the same edge as the state/counter (no extra latency).
REQ-024 BCD digit values 10-15 SHALL never appear on disp.

Reset
REQ-025 On rst high, immediately and independent of clk: state=IDLE, live counter=0, lap register=0, disp=24'h000000, running=0, lap_active=0.
REQ-026 Button previous-sample registers SHALL reset to 1 so a button held through reset release fires no event until released and re-pressed.
REQ-027 Reset asserted mid-count or in LAP SHALL discard all state; no tick or button in the reset-release cycle SHALL act unless btn rose after release.

Verification
REQ-028 Reset, ss pulse, 150 ticks, ss pulse -> state PAUSE, disp=24'h000150, running=0.
REQ-029 RUN at 00:12.34, lap pulse, 100 ticks -> disp holds 24'h001234, lap_active=1; lap pulse -> disp=24'h001334, state RUN.
REQ-030 PAUSE, btn_ss and btn_clr rise same cycle -> state IDLE, disp=0; ss held high, 10 ticks -> no count, no event.
REQ-031 RUN at 59:59.99, tick: WRAP_EN=1 -> disp=0, state RUN; WRAP_EN=0 -> disp=24'h595999, state PAUSE.
REQ-032 RUN, ss rise coincident with tick at 00:00.09 -> disp=24'h000010, state PAUSE; further ticks ignored.
REQ-033 btn_lap held high across rst deassert in RUN-then-reset scenario -> state IDLE, no LAP entry until release and re-press.
